fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO's write domain. Shares the single write port (winc/wdata, gated by full) among NREQ JTAG-side requesters with a valid/ready handshake. Sits in the wclk domain directly upstream of the write-pointer block: its winc drives the pointer's increment, and it consumes that block's full flag.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: FIFO word width.
- CNT_WIDTH, 16: width of the written-word counter.

Ports:
- wclk  input  1  write-domain clock; all state on its rising edge.
- w_rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  per-requester word valid.
- req_data  input  NREQ*DATA_WIDTH  flattened words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NREQ  last word of a burst (used only with burst lock).
- req_ready  output  NREQ  one-hot; word accepted when valid&&ready.
- full  input  1  FIFO full from write-pointer logic.
- winc  output  1  write strobe to FIFO.
- wdata  output  DATA_WIDTH  write data to FIFO.
- grant_id  output  $clog2(NREQ)  currently granted requester.
- busy  output  1  high in GRANT/LOCK state.
- wr_count  output  CNT_WIDTH  total words written, wraps modulo 2^CNT_WIDTH.

## Operation
- States: IDLE, GRANT, and LOCK (LOCK exists only with burst lock).
- IDLE: no ready asserted. If any req_valid is high, pick a winner by round-robin starting at last_grant+1. Register it into grant_id and go to GRANT.
- GRANT: req_ready[grant_id] = !full. winc = req_valid[grant_id] && !full. wdata = the granted slice, combinational mux.
- On transfer (winc=1): last_grant <= grant_id and wr_count increments.
  - If any requester is valid, re-pick immediately (the current requester has lowest priority) and stay in GRANT; no bubble between requesters.
  - Otherwise go to IDLE.
- Full: while full=1, winc=0 and all ready=0. Grant and state hold; no re-arbitration.
- Protocol rule: a requester holds valid and data stable until accepted. If req_valid[grant_id] falls without a transfer, go to IDLE next cycle and leave last_grant unchanged.
- winc is never high when full=1 or in IDLE.
- At most one ready bit is high; ready is zero for every non-granted requester.

## Timing
- Reset values: state IDLE, grant_id 0, last_grant NREQ-1 (so requester 0 has first priority), winc 0, req_ready 0, busy 0, wr_count 0, wdata 0 in IDLE.
- Latency: valid rises in cycle N (state IDLE) -> grant registered at edge N+1 -> winc high in cycle N+1 if !full.
- Throughput: one word per cycle while any requester is valid and full=0.
- full rising during GRANT takes effect combinationally in the same cycle: winc=0 that cycle.
- w_rst asserted mid-burst or with full=1: all state returns to reset values at the next edge, regardless of the handshake in flight.
- wr_count wraps from 2^CNT_WIDTH-1 to 0.

## Configuration
- Macro: FIFO_WR_ARB_BURST_LOCK_EN.
- Defined: a transfer with req_last[grant_id]=0 moves or keeps the state in LOCK, with no re-arbitration. A transfer with req_last=1 exits LOCK and re-arbitrates as in GRANT. Dropping valid in LOCK without a transfer holds the lock and does not go to IDLE. Output behaviour in LOCK is otherwise identical to GRANT.
- Undefined: LOCK state and req_last logic are absent; req_last is ignored. Arbitration is per word.

## Structure
- jtag_types_pkg holds:
  - warb_state_t enum (IDLE, GRANT, LOCK).
  - WARB_MAX_REQ = 8.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector and last_grant.
  - Outputs: any and winner index.
  - Used for both the IDLE pick and the post-transfer re-pick.

## Test plan
- Reset: assert w_rst for 2 cycles with all req_valid=1 -> winc=0, req_ready=0, grant_id=0, wr_count=0. First write after release is requester 0.
- Round-robin, NREQ=4: all four requesters continuously valid with data 0xA0+i, full=0 -> wdata sequence A0,A1,A2,A3,A0, one per cycle after the first grant; wr_count=5.
- Full stall: single requester streams; force full=1 for 3 cycles -> winc=0 and ready=0 for exactly those cycles; no word lost or duplicated; grant_id unchanged.
- Idle/re-entry: requester 2 sends one word, then nothing is valid -> state IDLE, busy=0. Requester 1 raises valid -> winc one cycle later with requester 1's data.
- Burst lock, macro defined: requesters 0 and 1 valid; requester 0 sends 3 words with last on the third -> three consecutive requester-0 writes, then requester 1. With the macro undefined, the same stimulus interleaves 0,1,0,1,0.
- Counter wrap, CNT_WIDTH=4: 17 writes -> wr_count=1.

Source files
------------

// File: rtl/jtag_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : jtag_types_pkg                                              |
// | Shared types and limits for the FIFO write-domain arbiter.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package jtag_types_pkg;

  // Arbiter state encoding; LOCK is only reachable with burst lock enabled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } warb_state_t;

  // Largest supported requester count.
  localparam int WARB_MAX_REQ = 8;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick                                                    |
// | Combinational round-robin picker: the requester following 'last' in |
// | circular order has highest priority, 'last' itself the lowest.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_pick
  import jtag_types_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int c_ID_W = $clog2(NREQ);

  int w_rank;
  int w_best;

  // Rank each requester by its circular distance after 'last'; lowest rank wins.
  always_comb begin
    any    = |req;
    winner = '0;
    w_best = NREQ;
    w_rank = 0;
    for (int j = 0; j < NREQ; j++) begin
      w_rank = j - int'(last) - 1;
      if (w_rank < 0) begin
        w_rank = w_rank + NREQ;
      end
      if (req[j] && (w_rank < w_best)) begin
        w_best = w_rank;
        winner = c_ID_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_wr_arbiter                                            |
// | Round-robin arbiter sharing the FIFO write port (winc/wdata, gated  |
// | by full) among NREQ valid/ready requesters, wclk domain.            |
// | Optional macro FIFO_WR_ARB_BURST_LOCK_EN: keep the grant until the  |
// | requester presents a word with req_last set.                        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fifo_wr_arbiter
  import jtag_types_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         wclk,
  input  logic                         w_rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         full,
  output logic                         winc,
  output logic [DATA_WIDTH-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         wr_count
);

  localparam int         c_ID_W     = $clog2(NREQ);
  localparam logic [1:0] c_ST_IDLE  = IDLE;
  localparam logic [1:0] c_ST_GRANT = GRANT;
  localparam logic [1:0] c_ST_LOCK  = LOCK;

  logic [1:0]            r_state;
  logic [c_ID_W-1:0]     r_grant;
  logic [c_ID_W-1:0]     r_last;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_active;
  logic                  w_in_lock;
  logic                  w_xfer;
  logic                  w_any;
  logic                  w_burst_cont;
  logic [c_ID_W-1:0]     w_base;
  logic [c_ID_W-1:0]     w_winner;
  logic [DATA_WIDTH-1:0] w_words [NREQ];

  // Unpack the flattened request words into an indexable view.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
    assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
  // A transferred word without req_last keeps the port owned by this requester.
  assign w_burst_cont = ~req_last[r_grant];
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_burst_cont  = 1'b0;
`endif

  assign w_active  = (r_state != c_ST_IDLE);
  assign w_in_lock = (r_state == c_ST_LOCK);
  assign w_xfer    = w_active & req_valid[r_grant] & ~full;
  assign winc      = w_xfer;
  assign busy      = w_active;
  assign grant_id  = r_grant;
  assign wr_count  = r_cnt;

  // In IDLE rotate from the last writer; after a transfer the current owner
  // becomes the lowest priority, which is the same rotation base.
  assign w_base = w_active ? r_grant : r_last;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req_valid),
    .last   (w_base),
    .any    (w_any),
    .winner (w_winner)
  );

  // Only the granted requester sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (w_active && !full) begin
      req_ready[r_grant] = 1'b1;
    end
  end

  // Write data follows the grant combinationally; zero while idle.
  always_comb begin
    wdata = '0;
    if (w_active) begin
      wdata = w_words[r_grant];
    end
  end

  // Grant/state sequencing, last-writer tracking and the written-word counter.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      r_state <= c_ST_IDLE;
      r_grant <= '0;
      r_last  <= c_ID_W'(NREQ - 1);
      r_cnt   <= '0;
    end else if (!w_active) begin
      if (w_any) begin
        r_state <= c_ST_GRANT;
        r_grant <= w_winner;
      end
    end else if (!full) begin
      if (w_xfer) begin
        r_last <= r_grant;
        r_cnt  <= r_cnt + 1'b1;
        if (w_burst_cont) begin
          r_state <= c_ST_LOCK;
        end else if (w_any) begin
          r_state <= c_ST_GRANT;
          r_grant <= w_winner;
        end else begin
          r_state <= c_ST_IDLE;
        end
      end else begin
        // Owner withdrew without a transfer: a held lock survives, a plain grant lapses.
        r_state <= w_in_lock ? c_ST_LOCK : c_ST_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fifo_wr_arbiter                                         |
// | Self-checking bench for fifo_wr_arbiter (NREQ=4, CNT_WIDTH=4):      |
// | queue-based requesters, cycle model of port ownership, directed     |
// | literal checks and a randomized phase.                              |
// | Honours FIFO_WR_ARB_BURST_LOCK_EN for its expectations.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int IDW  = 2;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef logic [DW:0] word_t;  // bit DW = last flag

  logic                 clk = 1'b0;
  logic                 w_rst;
  logic                 full;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 winc;
  logic [DW-1:0]        wdata;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic [CW-1:0]        wr_count;

  int n_checks = 0;
  int n_err    = 0;

  word_t q [NREQ][$];

  fifo_wr_arbiter #(
    .NREQ       (NREQ),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .wclk      (clk),
    .w_rst     (w_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Next requester after 'base' in circular order that is valid, or -1.
  function automatic int rr(input logic [NREQ-1:0] v, input int base);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (v[IDW'(idx)]) return idx;
    end
    return -1;
  endfunction

  // Requesters: each presents the head of its queue, pops it once accepted.
  initial begin
    logic [NREQ-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = q[i][0][DW-1:0];
          req_last[i]           = q[i][0][DW];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Model of who owns the port; compared against the DUT every cycle.
  initial begin
    bit              m_busy, m_lock;
    int              m_grant, m_last, m_cnt, p;
    logic            e_winc;
    logic [NREQ-1:0] e_ready;
    logic [DW-1:0]   e_wdata;
    m_busy = 0; m_lock = 0; m_grant = 0; m_last = NREQ - 1; m_cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_winc  = m_busy && req_valid[IDW'(m_grant)] && !full;
      e_ready = (m_busy && !full) ? (NREQ'(1) << m_grant) : '0;
      e_wdata = m_busy ? req_data[m_grant*DW +: DW] : '0;
      check("m_winc",  64'(winc),     64'(e_winc));
      check("m_ready", 64'(req_ready), 64'(e_ready));
      check("m_wdata", 64'(wdata),    64'(e_wdata));
      check("m_grant", 64'(grant_id), 64'(m_grant));
      check("m_busy",  64'(busy),     64'(m_busy));
      check("m_count", 64'(wr_count), 64'(m_cnt));
      if (w_rst) begin
        m_busy = 0; m_lock = 0; m_grant = 0; m_last = NREQ - 1; m_cnt = 0;
      end else if (!m_busy) begin
        p = rr(req_valid, m_last);
        if (p >= 0) begin m_busy = 1; m_grant = p; end
      end else if (!full) begin
        if (e_winc) begin
          m_cnt  = (m_cnt + 1) % (1 << CW);
          m_last = m_grant;
          if (LOCK_EN && !req_last[IDW'(m_grant)]) begin
            m_lock = 1;
          end else begin
            m_lock = 0;
            p = rr(req_valid, m_grant);
            if (p >= 0) m_grant = p; else m_busy = 0;
          end
        end else if (!m_lock) begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    bit done = 0;
    while (!done && n < 300) begin
      @(negedge clk); #1;
      done = !busy && (req_valid == '0);
      for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) done = 0;
      n++;
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL drain: got busy=%0b expected idle within 300 cycles", busy);
    end
  endtask

  task automatic wait_winc(input string nm);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!winc && n < 50);
    if (!winc) begin
      n_checks++; n_err++;
      $display("FAIL %s: got no winc expected one within 50 cycles", nm);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2; w_rst = 1'b1;
    @(posedge clk); #2; w_rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0]  rr_exp [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    int             b_exp  [5];
    int             b_got  [5];
    logic [CW-1:0]  cnt0;
    int             n, lim, len;

    w_rst = 1'b1;
    full  = 1'b0;

    // Reset with every requester valid, then round-robin A0..A3,A0.
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 6; k++) q[i].push_back({1'b1, DW'(32'hA0 + i)});
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_winc",  64'(winc),      64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_grant", 64'(grant_id),  64'(0));
    check("rst_count", 64'(wr_count),  64'(0));
    @(posedge clk); #2; w_rst = 1'b0;
    @(negedge clk); #1;
    check("idle_latency_winc", 64'(winc), 64'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("rr_winc",  64'(winc),  64'(1));
      check("rr_wdata", 64'(wdata), 64'(rr_exp[k]));
    end
    @(negedge clk); #1;
    check("rr_count", 64'(wr_count), 64'(5));
    drain();

    // Full stall on a single streaming requester.
    for (int k = 0; k < 8; k++) q[3].push_back({1'b1, DW'(32'h300 + k)});
    wait_winc("stall_start");
    cnt0 = wr_count;
    @(posedge clk); #2; full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("stall_winc",  64'(winc),      64'(0));
      check("stall_ready", 64'(req_ready), 64'(0));
      check("stall_grant", 64'(grant_id),  64'(3));
    end
    @(posedge clk); #2; full = 1'b0;
    @(negedge clk); #1;
    check("stall_resume", 64'(winc), 64'(1));
    drain();
    check("stall_words", 64'(CW'(wr_count - cnt0)), 64'(8));

    // Single word from requester 2, idle, then re-entry by requester 1.
    q[2].push_back({1'b1, DW'(32'h22)});
    @(negedge clk); #1;
    check("re_idle_winc", 64'(winc), 64'(0));
    @(negedge clk); #1;
    check("re_w2_winc",  64'(winc),  64'(1));
    check("re_w2_wdata", 64'(wdata), 64'(32'h22));
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("re_idle_busy", 64'(busy), 64'(0));
    q[1].push_back({1'b1, DW'(32'h11)});
    @(negedge clk); #1;
    check("re_w1_wait",  64'(winc),     64'(0));
    @(negedge clk); #1;
    check("re_w1_winc",  64'(winc),     64'(1));
    check("re_w1_wdata", 64'(wdata),    64'(32'h11));
    check("re_w1_grant", 64'(grant_id), 64'(1));
    drain();

    // Bursts of three from requesters 0 and 1.
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      q[0].push_back({(k == 2), DW'(32'hB0 + k)});
      q[1].push_back({(k == 2), DW'(32'hC0 + k)});
    end
    if (LOCK_EN) b_exp = '{0, 0, 0, 1, 1};
    else         b_exp = '{0, 1, 0, 1, 0};
    n = 0; lim = 0;
    while (n < 5 && lim < 60) begin
      @(negedge clk); #1;
      if (winc) begin b_got[n] = int'(grant_id); n++; end
      lim++;
    end
    for (int k = 0; k < 5; k++) begin
      if (k < n) check("burst_order", 64'(b_got[k]), 64'(b_exp[k]));
      else       check("burst_order_missing", 64'(n), 64'(5));
    end
    drain();

    // Reset while full and mid-stream.
    for (int k = 0; k < 6; k++) q[0].push_back({(k == 5), DW'(32'hD0 + k)});
    wait_winc("rstfull_start");
    @(posedge clk); #2; full = 1'b1; w_rst = 1'b1;
    @(negedge clk); #1;
    check("rstfull_winc", 64'(winc), 64'(0));
    @(negedge clk); #1;
    check("rstfull_busy",  64'(busy),     64'(0));
    check("rstfull_grant", 64'(grant_id), 64'(0));
    check("rstfull_count", 64'(wr_count), 64'(0));
    @(posedge clk); #2; full = 1'b0; w_rst = 1'b0;
    drain();

    // Counter wrap: 17 writes on a 4-bit counter.
    pulse_reset();
    for (int k = 0; k < 17; k++) q[1].push_back({1'b1, DW'(32'hE00 + k)});
    n = 0; lim = 0;
    while (n < 17 && lim < 100) begin
      @(negedge clk); #1;
      if (winc) n++;
      lim++;
    end
    @(negedge clk); #1;
    check("wrap_writes", 64'(n),        64'(17));
    check("wrap_count",  64'(wr_count), 64'(1));
    drain();

    // Randomized traffic with random full and occasional reset.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #2;
      full  = ($urandom % 5) == 0;
      w_rst = ($urandom % 150) == 0;
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() < 2 && ($urandom % 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) q[i].push_back({(k == len - 1), DW'($urandom)});
        end
      end
    end
    @(posedge clk); #2; full = 1'b0; w_rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
